// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - SAP-1 T-state ring counter, opcode decoder and halt latch
// Optional build macro VARIABLE_CYCLE_EN: skip T-states whose control word would be NOP.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic        nCLK,
  input  logic        CLR,
  input  logic [3:0]  OPCODE,
  output logic [11:0] CON,
  output logic [5:0]  T_STATE,
  output logic        HALT
);

  // Control word bit order: {Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo}
  localparam logic [11:0] CW_NOP   = 12'h3E3;
  localparam logic [11:0] CW_T1    = 12'h5E3;
  localparam logic [11:0] CW_T2    = 12'hBE3;
  localparam logic [11:0] CW_T3    = 12'h263;
  localparam logic [11:0] CW_MEMA  = 12'h1A3;
  localparam logic [11:0] CW_LDA5  = 12'h2C3;
  localparam logic [11:0] CW_LDB5  = 12'h2E1;
  localparam logic [11:0] CW_ADD6  = 12'h3C7;
  localparam logic [11:0] CW_SUB6  = 12'h3CF;
  localparam logic [11:0] CW_OUT4  = 12'h3F2;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  tstate_t state;
  logic    halted;
  logic    hlt_now;
  logic    known_op;

  assign hlt_now  = (state == T4) && (OPCODE == OP_HLT);
  assign known_op = (OPCODE == OP_LDA) || (OPCODE == OP_ADD) || (OPCODE == OP_SUB) ||
                    (OPCODE == OP_OUT) || (OPCODE == OP_HLT);

  // Ring counter and sticky halt latch; once halted only CLR releases the machine
  always_ff @(posedge nCLK or posedge CLR) begin
    if (CLR) begin
      state  <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      if (hlt_now) begin
        halted <= 1'b1;
      end else begin
        case (state)
          T1: state <= T2;
          T2: state <= T3;
`ifdef VARIABLE_CYCLE_EN
          T3: state <= known_op ? T4 : T1;
          T4: state <= (OPCODE == OP_OUT) ? T1 : T5;
          T5: state <= (OPCODE == OP_LDA) ? T1 : T6;
`else
          T3: state <= T4;
          T4: state <= T5;
          T5: state <= T6;
`endif
          T6: state <= T1;
          default: state <= T1;
        endcase
      end
    end
  end

  // Control word decode; the opcode only matters after the IR has loaded at the end of T3
  always_comb begin
    CON = CW_NOP;
    if (!CLR && !halted) begin
      case (state)
        T1: CON = CW_T1;
        T2: CON = CW_T2;
        T3: CON = CW_T3;
        T4: begin
          case (OPCODE)
            OP_LDA, OP_ADD, OP_SUB: CON = CW_MEMA;
            OP_OUT:                 CON = CW_OUT4;
            default:                CON = CW_NOP;
          endcase
        end
        T5: begin
          case (OPCODE)
            OP_LDA:         CON = CW_LDA5;
            OP_ADD, OP_SUB: CON = CW_LDB5;
            default:        CON = CW_NOP;
          endcase
        end
        T6: begin
          case (OPCODE)
            OP_ADD:  CON = CW_ADD6;
            OP_SUB:  CON = CW_SUB6;
            default: CON = CW_NOP;
          endcase
        end
        default: CON = CW_NOP;
      endcase
    end
  end

  assign T_STATE = state;
  assign HALT    = !CLR && (halted || hlt_now);

  // known_op only steers the variable-length sequencing
  logic unused_known;
  assign unused_known = known_op;

endmodule
